pipe_stage_skid: RTL

//  Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - One generic stage carries a payload word plus a control-signal vector between pipeline stages.
//  - Uses a valid/ready handshake. A 2-entry skid buffer keeps upstream ready a pure register output.
//  - Supports a synchronous flush for branch mispredict. Bubbles always present all-zero control.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_skid_entry.sv | 47 ++++
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage: default widths,
// the control-vector layout and the bubble (NOP) encoding.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // Control signals carried alongside the payload between stages
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jump;
    } ctrl_t;

    localparam int CTRL_W_DEF = $bits(ctrl_t);

    // A bubble carries no control activity at all
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the stage: a valid bit plus payload and control.
// load has priority over clear so a slot can be refilled while it drains.
// Payload registers are left unreset; the valid bit qualifies them.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    // Valid bit: set on load, dropped on clear, zero out of reset
    always_ff @(posedge clk) begin
        if (reset)
            valid_reg <= 1'b0;
        else if (load)
            valid_reg <= 1'b1;
        else if (clear)
            valid_reg <= 1'b0;
    end

    // Payload capture; contents only matter while valid_reg is set
    always_ff @(posedge clk) begin
        if (load) begin
            data_reg <= d_data;
            ctrl_reg <= d_ctrl;
        end
    end

    assign q_valid = valid_reg;
    assign q_data  = data_reg;
    assign q_ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// A main entry (M) drives the outputs; a skid entry (S) absorbs the one
// word that may arrive in the cycle a stall begins, so in_ready can be a
// plain register (= not S valid) without losing throughput.
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall/flush
// counters and their output ports.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data, m_d_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
    logic              m_load, m_clear, m_from_skid;
    logic              s_load, s_clear;
    logic              s_valid_next;
    logic              in_ready_reg;
    logic              accept, m_free;

    assign accept = in_valid & in_ready_reg;
    assign m_free = ~m_valid | out_ready;

    // Slot steering: flush empties both, otherwise M refills from S first
    // (S always holds the older word), then from the input; a stalled M
    // sends an accepted word into S.
    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (m_free) begin
            if (s_valid) begin
                m_load      = 1'b1;
                m_from_skid = 1'b1;
                s_clear     = 1'b1;
                s_load      = accept;
            end else if (accept) begin
                m_load = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (accept) begin
            s_load = 1'b1;
        end
    end

    assign m_d_data     = m_from_skid ? s_data : in_data;
    assign m_d_ctrl     = m_from_skid ? s_ctrl : in_ctrl;
    assign s_valid_next = s_load ? 1'b1 : (s_clear ? 1'b0 : s_valid);

    pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (m_load),
        .clear   (m_clear),
        .d_data  (m_d_data),
        .d_ctrl  (m_d_ctrl),
        .q_valid (m_valid),
        .q_data  (m_data),
        .q_ctrl  (m_ctrl)
    );

    pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (s_load),
        .clear   (s_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (s_valid),
        .q_data  (s_data),
        .q_ctrl  (s_ctrl)
    );

    // Upstream ready is registered: open whenever S will be empty next cycle
    always_ff @(posedge clk) begin
        if (reset)
            in_ready_reg <= 1'b0;
        else
            in_ready_reg <= ~s_valid_next;
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data : '0;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_W'(CTRL_NOP);

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             flush_kill;

    assign flush_kill = flush & (m_valid | s_valid | accept);

    // Saturating count of cycles where a valid word waits on downstream
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_reg <= '0;
        else if (m_valid && !out_ready && stall_cnt_reg != '1)
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    // Saturating count of flushes that actually discarded a word
    always_ff @(posedge clk) begin
        if (reset)
            flush_cnt_reg <= '0;
        else if (flush_kill && flush_cnt_reg != '1)
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule
